// File: rtl/instr_issue_queue.sv
// Instruction issue queue: a circular FIFO of instruction words drained by a
// paced issuer that presents one word every GAP_CYCLES cycles while run is high.
//
// Optional feature macro: ISSUE_HALT_DETECT_EN. When defined, a head word whose
// top 6 bits are 6'h3F is a halt word: it is popped without being presented and
// the block stops issuing until reset. When undefined, such words issue normally
// and halted is tied low.
//
// Ports:
//   clock        single clock, rising edge
//   reset        synchronous, active-high
//   push         enqueue push_word this cycle (dropped while full)
//   push_word    instruction to enqueue
//   run          issuing enabled while high
//   instrword    last issued instruction, held between issues
//   newinstr     one-cycle pulse marking a fresh instrword
//   full, empty  queue status
//   level        occupied entries
//   issued_count instructions issued since reset (wraps)
//   halted       halt word seen (always 0 without ISSUE_HALT_DETECT_EN)
module instr_issue_queue #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned GAP_CYCLES = 12
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_word,
  input  logic                     run,
  output logic [WIDTH-1:0]         instrword,
  output logic                     newinstr,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic [15:0]              issued_count,
  output logic                     halted
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam int unsigned GapW = $clog2(GAP_CYCLES + 1);

`ifdef ISSUE_HALT_DETECT_EN
  typedef enum logic [1:0] {StIdle, StWait, StHalt} state_e;
`else
  typedef enum logic {StIdle, StWait} state_e;
`endif

  state_e            state_q, state_d;
  logic [GapW-1:0]   gap_q, gap_d;
  logic [PtrW-1:0]   rd_ptr_q, wr_ptr_q;
  logic [LvlW-1:0]   level_q, level_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  instr_q;
  logic              new_q;
  logic [15:0]       count_q;

  logic              push_ok;
  logic              can_issue;
  logic              do_issue;
  logic              pop;
  logic              present;
  logic              halt_set;
  logic              is_halt_word;
  logic [WIDTH-1:0]  head;

  assign full      = (level_q == LvlW'(DEPTH));
  assign empty     = (level_q == '0);
  assign push_ok   = push && !full;
  // Decision uses registered level, so a word pushed this cycle is not yet visible.
  assign can_issue = run && !empty;
  assign head      = mem_q[rd_ptr_q];

`ifdef ISSUE_HALT_DETECT_EN
  assign is_halt_word = (head[WIDTH-1 -: 6] == 6'h3F);
`else
  assign is_halt_word = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    do_issue = 1'b0;
    pop      = 1'b0;
    present  = 1'b0;
    halt_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (can_issue) do_issue = 1'b1;
      end
      StWait: begin
        // A pending gap always runs to completion, even with run low.
        if (gap_q == GapW'(1)) begin
          if (can_issue) do_issue = 1'b1;
          else           state_d  = StIdle;
        end else begin
          gap_d = gap_q - GapW'(1);
        end
      end
      default: ;  // StHalt: frozen until reset
    endcase
    if (do_issue) begin
      pop = 1'b1;
      if (is_halt_word) begin
`ifdef ISSUE_HALT_DETECT_EN
        state_d  = StHalt;
`endif
        gap_d    = '0;
        halt_set = 1'b1;
      end else begin
        state_d = StWait;
        gap_d   = GapW'(GAP_CYCLES);
        present = 1'b1;
      end
    end
    level_d = level_q + LvlW'(push_ok) - LvlW'(pop);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= StIdle;
      gap_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      level_q  <= '0;
      instr_q  <= '0;
      new_q    <= 1'b0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      level_q <= level_d;
      new_q   <= present;
      if (push_ok) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)     rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (present) begin
        instr_q <= head;
        count_q <= count_q + 16'd1;
      end
    end
  end

  // Storage needs no reset; pointers and level define validity.
  always_ff @(posedge clock) begin
    if (!reset && push_ok) mem_q[wr_ptr_q] <= push_word;
  end

`ifdef ISSUE_HALT_DETECT_EN
  logic halted_q;
  always_ff @(posedge clock) begin
    if (reset)         halted_q <= 1'b0;
    else if (halt_set) halted_q <= 1'b1;
  end
  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  assign instrword    = instr_q;
  assign newinstr     = new_q;
  assign level        = level_q;
  assign issued_count = count_q;

endmodule

// File: tb/tb_instr_issue_queue.sv
// Bench for instr_issue_queue: directed scenarios plus randomized traffic checked
// against a queue-based reference model (issue allowed when the queue is non-empty,
// run is high and at least GAP cycles have passed since the previous issue).
module tb_instr_issue_queue;
  localparam int W = 32;
  localparam int D = 8;
  localparam int G = 12;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset, push, run;
  logic [W-1:0]  push_word;
  logic [W-1:0]  instrword;
  logic          newinstr, full, empty, halted;
  logic [3:0]    level;
  logic [15:0]   issued_count;

  logic          reset2, push2, run2;
  logic [W-1:0]  word2, instr2;
  logic          new2, full2, empty2, halted2;
  logic [2:0]    level2;
  logic [15:0]   count2;

  int checks = 0;
  int failures = 0;

  instr_issue_queue #(.WIDTH(W), .DEPTH(D), .GAP_CYCLES(G)) dut (
    .clock(clock), .reset(reset), .push(push), .push_word(push_word), .run(run),
    .instrword(instrword), .newinstr(newinstr), .full(full), .empty(empty),
    .level(level), .issued_count(issued_count), .halted(halted)
  );

  instr_issue_queue #(.WIDTH(W), .DEPTH(4), .GAP_CYCLES(2)) dut2 (
    .clock(clock), .reset(reset2), .push(push2), .push_word(word2), .run(run2),
    .instrword(instr2), .newinstr(new2), .full(full2), .empty(empty2),
    .level(level2), .issued_count(count2), .halted(halted2)
  );

  // Reference model for dut
  logic [W-1:0] mq[$];
  logic [W-1:0] m_instr, m_w;
  logic         m_new, m_halted, m_accept, m_issue, m_is_halt;
  logic [15:0]  m_count;
  longint       cyc = 0;
  longint       last_issue = 0;
  bit           have_last = 0;

  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      mq.delete();
      m_instr = '0; m_new = 1'b0; m_count = '0; m_halted = 1'b0; have_last = 0;
    end else begin
      m_accept = push && (mq.size() < D);
      m_issue  = !m_halted && run && (mq.size() > 0) && (!have_last || (cyc - last_issue >= G));
      m_new    = 1'b0;
      if (m_issue) begin
        m_w = mq.pop_front();
        last_issue = cyc;
        have_last = 1;
        m_is_halt = 1'b0;
`ifdef ISSUE_HALT_DETECT_EN
        m_is_halt = (m_w[31:26] == 6'h3F);
`endif
        if (m_is_halt) m_halted = 1'b1;
        else begin
          m_instr = m_w; m_new = 1'b1; m_count = m_count + 16'd1;
        end
      end
      if (m_accept) mq.push_back(push_word);
    end
  end

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1; push = 1'b0; run = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; push = 1'b1; push_word = 32'hDEADBEEF; run = 1'b1;
    tick();
    checks++;
    if ({instrword, newinstr, level, full, empty, issued_count, halted} !==
        {32'h0, 1'b0, 4'd0, 1'b0, 1'b1, 16'd0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state instr=%h new=%b level=%0d full=%b empty=%b cnt=%0d halt=%b",
               instrword, newinstr, level, full, empty, issued_count, halted);
    end
    reset = 1'b0; push = 1'b0; run = 1'b0;
    tick();
    checks++;
    if (level !== 4'd0) begin
      failures++; $display("FAIL reset_overrides_push level=%0d expected 0", level);
    end
  endtask

  task automatic test_basic();
    logic [W-1:0] w[3] = '{32'h8C010000, 32'h8C020001, 32'h8C030002};
    int pos[$];
    logic [W-1:0] got[$];
    do_reset();
    run = 1'b1;
    for (int t = 1; t <= 45; t++) begin
      push = (t <= 3);
      if (t <= 3) push_word = w[t-1];
      tick();
      if (newinstr) begin pos.push_back(t); got.push_back(instrword); end
    end
    push = 1'b0;
    checks++;
    if (pos.size() != 3) begin
      failures++; $display("FAIL basic_pulse_count got=%0d expected 3", pos.size());
    end
    for (int i = 0; i < pos.size() && i < 3; i++) begin
      checks++;
      if (pos[i] != 2 + 12 * i || got[i] !== w[i]) begin
        failures++;
        $display("FAIL basic_issue%0d cycle=%0d word=%h expected cycle=%0d word=%h",
                 i, pos[i], got[i], 2 + 12 * i, w[i]);
      end
    end
    checks++;
    if ({issued_count, empty, level} !== {16'd3, 1'b1, 4'd0}) begin
      failures++;
      $display("FAIL basic_final cnt=%0d empty=%b level=%0d expected 3 1 0",
               issued_count, empty, level);
    end
  endtask

  task automatic test_full();
    int n = 0;
    logic [W-1:0] got[$];
    do_reset();
    for (int i = 0; i < 9; i++) begin
      push = 1'b1; push_word = 32'h1000_0000 + i;
      tick();
      if (i == 7) begin
        checks++;
        if ({full, level} !== {1'b1, 4'd8}) begin
          failures++; $display("FAIL full_after8 full=%b level=%0d expected 1 8", full, level);
        end
      end
    end
    push = 1'b0;
    checks++;
    if ({full, empty, level} !== {1'b1, 1'b0, 4'd8}) begin
      failures++;
      $display("FAIL full_ninth_dropped full=%b empty=%b level=%0d expected 1 0 8",
               full, empty, level);
    end
    run = 1'b1;
    for (int t = 0; t < 8 * G + 12; t++) begin
      tick();
      if (newinstr) begin n++; got.push_back(instrword); end
    end
    checks++;
    if (n != 8 || issued_count !== 16'd8 || empty !== 1'b1) begin
      failures++;
      $display("FAIL full_drain issues=%0d cnt=%0d empty=%b expected 8 8 1", n, issued_count, empty);
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== 32'h1000_0000 + i) begin
        failures++;
        $display("FAIL full_order%0d got=%h expected=%h", i, got[i], 32'h1000_0000 + i);
      end
    end
  endtask

  task automatic test_run_drop();
    int n = 0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; push_word = 32'hA000_0000 + i; tick();
    end
    push = 1'b0; run = 1'b1;
    tick();
    checks++;
    if ({newinstr, instrword} !== {1'b1, 32'hA000_0000}) begin
      failures++; $display("FAIL rundrop_first new=%b instr=%h expected 1 a0000000", newinstr, instrword);
    end
    run = 1'b0;
    for (int t = 0; t < 25; t++) begin
      tick();
      if (newinstr) n++;
    end
    checks++;
    if (n != 0 || level !== 4'd2) begin
      failures++; $display("FAIL rundrop_quiet pulses=%0d level=%0d expected 0 2", n, level);
    end
    run = 1'b1;
    tick();
    checks++;
    if ({newinstr, instrword, issued_count} !== {1'b1, 32'hA000_0001, 16'd2}) begin
      failures++;
      $display("FAIL rundrop_resume new=%b instr=%h cnt=%0d expected 1 a0000001 2",
               newinstr, instrword, issued_count);
    end
  endtask

  task automatic test_reset_mid_wait();
    int n = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; push_word = 32'hC000_0000 + i; tick();
    end
    push = 1'b0; run = 1'b1;
    tick();
    for (int t = 0; t < 5; t++) tick();
    checks++;
    if ({level, newinstr} !== {4'd3, 1'b0}) begin
      failures++; $display("FAIL midwait_pre level=%0d new=%b expected 3 0", level, newinstr);
    end
    reset = 1'b1; push = 1'b1;
    tick();
    checks++;
    if ({instrword, newinstr, level, full, empty, issued_count, halted} !==
        {32'h0, 1'b0, 4'd0, 1'b0, 1'b1, 16'd0, 1'b0}) begin
      failures++;
      $display("FAIL midwait_reset instr=%h new=%b level=%0d full=%b empty=%b cnt=%0d halt=%b",
               instrword, newinstr, level, full, empty, issued_count, halted);
    end
    reset = 1'b0; push = 1'b0;
    for (int t = 0; t < 30; t++) begin
      tick();
      if (newinstr) n++;
    end
    checks++;
    if (n != 0) begin
      failures++; $display("FAIL midwait_no_pulse pulses=%0d expected 0", n);
    end
    run = 1'b0;
  endtask

`ifdef ISSUE_HALT_DETECT_EN
  task automatic test_halt();
    logic [W-1:0] w[3] = '{32'h00852020, 32'hFC000000, 32'h00A32822};
    int n = 0;
    logic [W-1:0] first = '0;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      push = 1'b1; push_word = w[i]; tick();
    end
    push = 1'b0; run = 1'b1;
    for (int t = 0; t < 40; t++) begin
      tick();
      if (newinstr) begin n++; first = instrword; end
    end
    checks++;
    if (n != 1 || first !== 32'h00852020) begin
      failures++; $display("FAIL halt_one_issue issues=%0d word=%h expected 1 00852020", n, first);
    end
    checks++;
    if ({halted, level, issued_count, instrword} !== {1'b1, 4'd1, 16'd1, 32'h00852020}) begin
      failures++;
      $display("FAIL halt_state halted=%b level=%0d cnt=%0d instr=%h expected 1 1 1 00852020",
               halted, level, issued_count, instrword);
    end
    push = 1'b1; push_word = 32'h1234_5678; tick(); push = 1'b0;
    n = 0;
    for (int t = 0; t < 30; t++) begin
      tick();
      if (newinstr) n++;
    end
    checks++;
    if (n != 0 || level !== 4'd2 || halted !== 1'b1) begin
      failures++;
      $display("FAIL halt_frozen pulses=%0d level=%0d halted=%b expected 0 2 1", n, level, halted);
    end
    run = 1'b0;
  endtask
`else
  task automatic test_halt();
    do_reset();
    push = 1'b1; push_word = 32'hFC000000; run = 1'b1;
    tick();
    push = 1'b0;
    tick();
    checks++;
    if ({newinstr, instrword, halted, issued_count} !== {1'b1, 32'hFC000000, 1'b0, 16'd1}) begin
      failures++;
      $display("FAIL nohalt_issue new=%b instr=%h halted=%b cnt=%0d expected 1 fc000000 0 1",
               newinstr, instrword, halted, issued_count);
    end
    run = 1'b0;
  endtask
`endif

  task automatic test_back_to_back();
    logic [7:0] pat = '0;
    logic [W-1:0] got[$];
    reset2 = 1'b1; push2 = 1'b0; run2 = 1'b0;
    tick();
    reset2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push2 = 1'b1; word2 = 32'hB000_0000 + i; tick();
    end
    push2 = 1'b0;
    checks++;
    if ({full2, level2} !== {1'b1, 3'd4}) begin
      failures++; $display("FAIL b2b_full full=%b level=%0d expected 1 4", full2, level2);
    end
    run2 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      pat[7-i] = new2;
      if (new2) got.push_back(instr2);
    end
    checks++;
    if (pat !== 8'b1010_1010) begin
      failures++; $display("FAIL b2b_pattern got=%b expected 10101010", pat);
    end
    for (int i = 0; i < got.size(); i++) begin
      checks++;
      if (got[i] !== 32'hB000_0000 + i) begin
        failures++; $display("FAIL b2b_order%0d got=%h expected=%h", i, got[i], 32'hB000_0000 + i);
      end
    end
    checks++;
    if ({count2, empty2, level2, halted2} !== {16'd4, 1'b1, 3'd0, 1'b0}) begin
      failures++;
      $display("FAIL b2b_final cnt=%0d empty=%b level=%0d halted=%b expected 4 1 0 0",
               count2, empty2, level2, halted2);
    end
    run2 = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 1200; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      if (((i / 100) % 2) == 0) push = ($urandom_range(0, 3) != 0);
      else                      push = ($urandom_range(0, 3) == 0);
      push_word = $urandom;
      if ($urandom_range(0, 7) == 0) push_word[31:26] = 6'h3F;
      if ($urandom_range(0, 19) == 0) run = ~run;
      tick();
      checks++;
      if ({instrword, newinstr, level, full, empty, issued_count, halted} !==
          {m_instr, m_new, 4'(mq.size()), mq.size() == D, mq.size() == 0, m_count, m_halted}) begin
        failures++;
        $display("FAIL random_c%0d instr=%h/%h new=%b/%b level=%0d/%0d cnt=%0d/%0d halt=%b/%b",
                 i, instrword, m_instr, newinstr, m_new, level, mq.size(),
                 issued_count, m_count, halted, m_halted);
      end
    end
    reset = 1'b0; push = 1'b0; run = 1'b0;
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; run = 1'b0; push_word = '0;
    reset2 = 1'b1; push2 = 1'b0; run2 = 1'b0; word2 = '0;
    test_reset();
    test_basic();
    test_full();
    test_run_drop();
    test_reset_mid_wait();
    test_halt();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
